// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared types and constants for the FIFO stream reader
package fifo_rd_pkg;

  // Controller states: IDLE (quiescent), RUN (issuing reads), DRAIN (flushing pending words)
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  // Prefetch depth: covers the 1-cycle FIFO read latency plus one registered credit cycle
  localparam int unsigned BUF_DEPTH = 3;

  // Occupancy spans 0..BUF_DEPTH inclusive
  localparam int unsigned OCC_W = 2;
  // Pointers span 0..BUF_DEPTH-1
  localparam int unsigned PTR_W = 2;

  typedef logic [OCC_W-1:0] occ_t;
  typedef logic [PTR_W-1:0] ptr_t;

  // Circular pointer advance, wrapping at BUF_DEPTH (not a power of two)
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(BUF_DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// rtl/stream_skid_buf.sv - 3-entry circular prefetch buffer with push/pop and head data
module stream_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DWIDTH-1:0] push_data_i,
  input  logic              pop_i,
  output occ_t              occ_o,
  output logic [DWIDTH-1:0] head_data_o
);

  logic [DWIDTH-1:0] mem_q [BUF_DEPTH];
  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  occ_t occ_q, occ_d;

  // Next pointers and occupancy; a simultaneous push and pop leaves occupancy unchanged
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (push_i) begin
      tail_d = ptr_inc(tail_q);
    end
    if (pop_i) begin
      head_d = ptr_inc(head_q);
    end
    case ({push_i, pop_i})
      2'b10:   occ_d = occ_q + occ_t'(1);
      2'b01:   occ_d = occ_q - occ_t'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards any buffered words
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  // Storage: write the incoming word at the tail slot
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_i) begin
      mem_q[tail_q] <= push_data_i;
    end
  end

  assign occ_o       = occ_q;
  assign head_data_o = mem_q[head_q];

  // The upstream credit check must never let a push land on a full buffer
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !pop_i && (occ_q == occ_t'(BUF_DEPTH))));

  // Pops are only legal while something is held
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop_i && (occ_q == '0)));

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - pops a synchronous FIFO into a burst-framed valid/ready stream
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned CWIDTH    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_data_out,
  output logic              fifo_rd_cs,
  output logic              fifo_rd_en,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic [CWIDTH-1:0] beat_count
);

  // A single-beat burst still needs a 1-bit index register
  localparam int unsigned BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(BURST_LEN - 1);

  rd_state_e state_q, state_d;
  logic inflight_q;
  logic [BW-1:0] burst_idx_q, burst_idx_d;
  logic [CWIDTH-1:0] beat_count_q, beat_count_d;

  occ_t occ;
  logic [DWIDTH-1:0] head_data;
  logic [OCC_W:0] credit_used;
  logic issue;
  logic pop;
  logic pending;

  // Credits count both held words and the word still on its way from the FIFO,
  // so issue depends only on registered state and fifo_empty, never on m_ready.
  assign credit_used = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q};
  assign issue       = (state_q == RUN) && !fifo_empty &&
                       (credit_used < (OCC_W + 1)'(BUF_DEPTH));
  assign pending     = (occ != '0) || inflight_q;

  assign fifo_rd_cs = issue;
  assign fifo_rd_en = issue;

  assign m_valid    = (occ != '0);
  assign m_data     = head_data;
  assign pop        = m_valid && m_ready;
  assign m_last     = m_valid && (burst_idx_q == LAST_IDX);
  assign busy       = (state_q != IDLE);
  assign beat_count = beat_count_q;

  stream_skid_buf #(
    .DWIDTH(DWIDTH)
  ) u_skid_buf (
    .clk_i      (clk),
    .rst_ni     (rst),
    .push_i     (inflight_q),
    .push_data_i(fifo_data_out),
    .pop_i      (pop),
    .occ_o      (occ),
    .head_data_o(head_data)
  );

  // Next-state logic: dropping en keeps the block busy until every pending word has left
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = pending ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (en) begin
          state_d = RUN;
        end else if (!pending) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and the read-in-flight flag that marks next-edge capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
    end
  end

  // Burst position and total beat count advance on every accepted beat
  always_comb begin
    burst_idx_d  = burst_idx_q;
    beat_count_d = beat_count_q;
    if (pop) begin
      burst_idx_d  = (burst_idx_q == LAST_IDX) ? '0 : burst_idx_q + BW'(1);
      beat_count_d = beat_count_q + CWIDTH'(1);
    end
  end

  // Counter registers; burst position survives en toggles and only reset clears it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burst_idx_q  <= '0;
      beat_count_q <= '0;
    end else begin
      burst_idx_q  <= burst_idx_d;
      beat_count_q <= beat_count_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - self-checking bench for fifo_stream_reader
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int BL = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data_out;
  logic          fifo_rd_cs;
  logic          fifo_rd_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          busy;
  logic [CW-1:0] beat_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .DWIDTH   (DW),
    .BURST_LEN(BL),
    .CWIDTH   (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .fifo_empty   (fifo_empty),
    .fifo_data_out(fifo_data_out),
    .fifo_rd_cs   (fifo_rd_cs),
    .fifo_rd_en   (fifo_rd_en),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .busy         (busy),
    .beat_count   (beat_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO model: 1-cycle registered read latency
  logic [DW-1:0] fmem [0:63];
  int frd;
  int fwr = 0;
  assign fifo_empty = (frd == fwr);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      frd <= 0;
      fifo_data_out <= '0;
    end else if (fifo_rd_en) begin
      checks++;
      if (frd == fwr) begin
        errors++;
        $display("FAIL read_when_empty: rd_en=1 with empty FIFO at %0t", $time);
      end
      if (fifo_rd_cs !== 1'b1) begin
        errors++;
        $display("FAIL rd_cs: got %0b expected 1 at %0t", fifo_rd_cs, $time);
      end
      fifo_data_out <= fmem[frd % 64];
      frd <= frd + 1;
    end
  end

  // Scoreboard of words expected downstream, filled when the FIFO is loaded
  logic [DW-1:0] sb_q [$];
  int sb_idx = 0;
  int pops = 0;
  logic          stall_q = 1'b0;
  logic [DW-1:0] stall_data;
  logic          stall_last;

  always @(negedge clk) begin
    if (!rst) begin
      sb_idx  = 0;
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        checks++;
        if (!(m_valid === 1'b1 && m_data === stall_data && m_last === stall_last)) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b d=%0h l=%0b expected v=1 d=%0h l=%0b",
                   m_valid, m_data, m_last, stall_data, stall_last);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: got beat %0h expected none", m_data);
        end else begin
          logic [DW-1:0] exp_d;
          exp_d = sb_q.pop_front();
          if (m_data !== exp_d) begin
            errors++;
            $display("FAIL sb_data: got %0h expected %0h", m_data, exp_d);
          end
        end
        chk("m_last", m_last, (sb_idx == BL - 1));
        sb_idx = (sb_idx == BL - 1) ? 0 : sb_idx + 1;
        pops++;
      end
      stall_q    = m_valid && !m_ready;
      stall_data = m_data;
      stall_last = m_last;
    end
  end

  task automatic load(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      fmem[fwr % 64] = DW'(base + i);
      sb_q.push_back(DW'(base + i));
      fwr = fwr + 1;
    end
  endtask

  task automatic fifo_put_unexpected(input logic [DW-1:0] w);
    fmem[fwr % 64] = w;
    fwr = fwr + 1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    en = 1'b0;
    m_ready = 1'b0;
    fwr = 0;
    sb_q.delete();
    pops = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) @(negedge clk);
    chk("drain_done", (sb_q.size() == 0), 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic          rd_en;
    logic          valid;
    logic [DW-1:0] data;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int strobes, last_pop, busy_low, pops_d;

    for (int c = 0; c < 8; c++) begin
      tbl[c].rd_en = (c <= 4);
      tbl[c].valid = (c >= 2 && c <= 6);
      tbl[c].data  = DW'(c - 1);
    end

    // Reset state, before any clock edge
    rst = 1'b0;
    en = 1'b0;
    m_ready = 1'b0;
    #3;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_beat_count", beat_count, 0);
    chk("rst_m_data", m_data, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Five words, ready held high: table of per-cycle expectations
    do_reset();
    m_ready = 1'b1;
    load(5, 1);
    en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("a_rd_en_c%0d", c), fifo_rd_en, tbl[c].rd_en);
      chk($sformatf("a_valid_c%0d", c), m_valid, tbl[c].valid);
      if (tbl[c].valid) chk($sformatf("a_data_c%0d", c), m_data, tbl[c].data);
    end
    chk("a_beat_count", beat_count, 5);

    // Downstream stall: only three reads outstanding, head word held
    do_reset();
    load(8, 1);
    en = 1'b1;
    strobes = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      strobes += int'(fifo_rd_en);
    end
    chk("b_strobes", strobes, 3);
    chk("b_valid", m_valid, 1);
    chk("b_data", m_data, 8'h01);
    @(posedge clk);
    #1 m_ready = 1'b1;
    drain(40);
    chk("b_pops", pops, 8);

    // Burst framing over ten beats
    do_reset();
    m_ready = 1'b1;
    load(10, 8'h10);
    en = 1'b1;
    drain(60);
    chk("c_beat_count", beat_count, 10);
    chk("c_burst_idx", dut.burst_idx_q, 2);

    // en drops in a strobe cycle with two words held
    do_reset();
    load(2, 1);
    en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    load(1, 3);
    fifo_put_unexpected(8'hA4);
    fifo_put_unexpected(8'hA5);
    en = 1'b0;
    @(negedge clk);
    chk("d_strobe", fifo_rd_en, 1);
    @(posedge clk);
    #1 m_ready = 1'b1;
    strobes = 0;
    last_pop = -1;
    busy_low = -1;
    pops_d = 0;
    for (int c = 4; c < 24; c++) begin
      if (c > 4) @(posedge clk);
      @(negedge clk);
      strobes += int'(fifo_rd_en);
      if (m_valid && m_ready) begin
        last_pop = c;
        pops_d++;
      end
      if (!busy && busy_low < 0) busy_low = c;
    end
    chk("d_strobes_after", strobes, 0);
    chk("d_pops", pops_d, 3);
    chk("d_busy_fall", busy_low, last_pop + 2);

    // Asynchronous reset mid-stream
    do_reset();
    m_ready = 1'b1;
    load(6, 8'h40);
    en = 1'b1;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("e_rd_cs", fifo_rd_cs, 0);
    chk("e_rd_en", fifo_rd_en, 0);
    chk("e_m_valid", m_valid, 0);
    chk("e_m_last", m_last, 0);
    chk("e_busy", busy, 0);
    chk("e_beat_count", beat_count, 0);
    chk("e_m_data", m_data, 0);
    sb_q.delete();
    fwr = 0;
    en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("e_post_valid", m_valid, 0);
    chk("e_post_beats", beat_count, 0);

    // Beat counter wrap at 2^CW
    do_reset();
    m_ready = 1'b1;
    load(17, 8'h60);
    en = 1'b1;
    drain(80);
    chk("f_beat_wrap", beat_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Consumer-side controller for the team's synchronous FIFO (chip-select/enable read port, registered data_out with 1-cycle read latency, empty flag). Pops words from the FIFO and presents them downstream on a valid/ready stream, framed into fixed-length bursts. A 3-entry prefetch buffer sustains 1 beat/cycle with no combinational path from m_ready to the FIFO read strobes.

Parameters:
DWIDTH, 8, data width; must match the FIFO DWIDTH
BURST_LEN, 16, beats per burst; m_last marks the final beat; must be >= 1
CWIDTH, 16, width of the total beat counter

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  asynchronous, active-low reset
en  in  1  enable reading from the FIFO
fifo_empty  in  1  FIFO empty flag
fifo_data_out  in  DWIDTH  FIFO read data; valid the cycle after a read strobe
fifo_rd_cs  out  1  FIFO read chip select
fifo_rd_en  out  1  FIFO read enable
m_data  out  DWIDTH  stream data
m_valid  out  1  stream valid
m_ready  in  1  stream ready
m_last  out  1  last beat of a burst
busy  out  1  block not IDLE
beat_count  out  CWIDTH  total beats accepted downstream since reset

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; buffer occupancy, in-flight flag, burst index and beat_count all 0. Outputs fifo_rd_cs, fifo_rd_en, m_valid, m_last, busy and beat_count are 0. m_data is 0. Buffered data is discarded.
- issue = (state==RUN) && !fifo_empty && (occ + inflight < 3).
  - issue is combinational from registered state and fifo_empty only.
  - fifo_rd_cs = fifo_rd_en = issue.
  - Never asserted while fifo_empty=1.
- inflight <= issue each cycle. When inflight=1, fifo_data_out is written into the buffer at the tail on that edge.
- Buffer: 3-entry circular buffer with head/tail pointers (mod 3), occ 0..3.
  - m_valid = (occ != 0).
  - m_data = entry at head.
  - pop = m_valid && m_ready.
  - Capture and pop in the same cycle: occ unchanged, both pointers advance.
  - The credit rule guarantees a capture never overflows; an overflow is a design error, flagged by an assertion.
- Latency: first issue at edge N; data captured at edge N+1; m_valid high after edge N+1 (cycle N+2 when counting the issue cycle as N). Steady-state throughput is 1 beat/cycle with m_ready=1.
- Stability: while m_valid=1 and m_ready=0, m_data and m_last hold.
- Burst framing:
  - burst_idx increments on pop and wraps to 0 after BURST_LEN-1.
  - m_last = m_valid && (burst_idx == BURST_LEN-1).
  - burst_idx is preserved across en toggles; only reset clears it.
- beat_count increments on every pop and wraps modulo 2^CWIDTH.
- State machine:
  - IDLE: en=1 -> RUN.
  - RUN: en=0 and (occ!=0 or inflight) -> DRAIN; en=0 with nothing pending -> IDLE.
  - DRAIN: no issue. en=1 -> RUN; occ==0 && !inflight -> IDLE.
  - busy = (state != IDLE).
- Boundary cases:
  - fifo_empty rising mid-run: issue stops, buffered data continues to drain.
  - en dropping while a read is in flight: the word is still captured and delivered.
  - Downstream stall: at most 3 reads outstanding plus buffered, then issue stops.

Decomposition:
- Package fifo_rd_pkg holds:
  - state enum: IDLE, RUN, DRAIN
  - localparam BUF_DEPTH=3
  - occupancy width constant
- One sub-module: stream_skid_buf, the 3-entry circular buffer with push/pop/occ/head-data. The top holds the FSM, credit, burst and beat counters.

Test Plan:
- Reset: assert rst=0 mid-stream with no clock edge -> all outputs 0 immediately; after release, m_valid=0 and beat_count=0.
- FIFO preloaded 0x01..0x05, en=1 at cycle 0, m_ready=1 -> fifo_rd_en high cycles 0-4; m_valid cycles 2-6 with data 0x01..0x05 in order; beat_count=5; fifo_rd_en never high once empty.
- Preload 8 words, m_ready=0 -> exactly 3 read strobes, then m_data=0x01 held. Release m_ready -> 0x01..0x08 with no loss or duplication.
- BURST_LEN=4, 10 words streamed -> m_last high on beats 4 and 8 only; burst_idx=2 at end; beat_count=10.
- Drop en in the cycle of a read strobe with 2 words buffered -> no further strobes; 3 words delivered; busy falls the cycle after the final pop.
- beat_count wrap with CWIDTH=4: 17 beats -> beat_count=1.
